// File: rtl/gpr_serial_bank.sv
// Bank of NREGS general-purpose registers, each read/written/rotated one bit per clock, LSB first.
// Optional parallel-load port is enabled by defining GPR_PARLOAD_EN.
module gpr_serial_bank #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = ($clog2(NREGS) > 1) ? $clog2(NREGS) : 1,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [AW-1:0]          i_addr,
  input  logic [1:0]             i_mode,
  input  logic                   i_data_in,
  output logic                   o_data_out,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [NREGS*WIDTH-1:0] o_regs
`ifdef GPR_PARLOAD_EN
  ,
  input  logic                   i_load,
  input  logic [AW-1:0]          i_load_addr,
  input  logic [WIDTH-1:0]       i_load_data
`endif
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [AW:0]   NREGS_L  = (AW + 1)'(NREGS);

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [AW-1:0]   addr_reg;
  logic [1:0]      mode_reg;
  logic            done_reg;
  logic            err_reg;

  logic [NREGS-1:0] lsb_vec;
  logic             shift_msb;
  logic             start_ok;
  logic             start_bad;
  logic             load_ok;

  assign start_ok  = i_start && ({1'b0, i_addr} < NREGS_L);
  assign start_bad = i_start && !({1'b0, i_addr} < NREGS_L);

`ifdef GPR_PARLOAD_EN
  // A load takes precedence over a start presented in the same idle cycle.
  assign load_ok = i_load && (state_reg == IDLE) && ({1'b0, i_load_addr} < NREGS_L);
`else
  assign load_ok = 1'b0;
`endif

  always_comb begin
    shift_msb = 1'b0;
    case (mode_reg)
      2'b00:   shift_msb = 1'b0;
      2'b01:   shift_msb = i_data_in;
      default: shift_msb = lsb_vec[addr_reg];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      mode_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!load_ok) begin
            if (start_ok) begin
              addr_reg  <= i_addr;
              mode_reg  <= i_mode;
              cnt_reg   <= '0;
              state_reg <= SHIFT;
            end else if (start_bad) begin
              err_reg <= 1'b1;
            end
          end
        end
        SHIFT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [WIDTH-1:0] data_reg;
      logic             shift_hit;

      assign shift_hit = (state_reg == SHIFT) && (addr_reg == AW'(gi));

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          data_reg <= '0;
`ifdef GPR_PARLOAD_EN
        end else if (load_ok && (i_load_addr == AW'(gi))) begin
          data_reg <= i_load_data;
`endif
        end else if (shift_hit) begin
          data_reg <= {shift_msb, data_reg[WIDTH-1:1]};
        end
      end

      assign lsb_vec[gi]                = data_reg[0];
      assign o_regs[gi*WIDTH +: WIDTH] = data_reg;
    end
  endgenerate

  assign o_busy     = (state_reg == SHIFT);
  assign o_done     = done_reg;
  assign o_err      = err_reg;
  assign o_data_out = (state_reg == SHIFT) ? lsb_vec[addr_reg] : 1'b0;

endmodule

// File: tb/tb_gpr_serial_bank.sv
// Scoreboard bench for gpr_serial_bank: a 4x8 bank for the main scenarios and a 5x8 bank
// for the out-of-range address case.
module tb_gpr_serial_bank;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, start = 1'b0, data_in = 1'b0;
  logic [1:0] addr = '0, mode = '0;
  wire        data_out, busy, done, err;
  wire [31:0] regs;

  logic       start5 = 1'b0, data_in5 = 1'b0;
  logic [2:0] addr5 = '0;
  logic [1:0] mode5 = '0;
  wire        data_out5, busy5, done5, err5;
  wire [39:0] regs5;

`ifdef GPR_PARLOAD_EN
  logic       load = 1'b0, load5 = 1'b0;
  logic [1:0] load_addr = '0;
  logic [2:0] load_addr5 = '0;
  logic [7:0] load_data = '0, load_data5 = '0;
`endif

  gpr_serial_bank #(.WIDTH(8), .NREGS(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_addr(addr), .i_mode(mode),
    .i_data_in(data_in), .o_data_out(data_out), .o_busy(busy), .o_done(done),
    .o_err(err), .o_regs(regs)
`ifdef GPR_PARLOAD_EN
    , .i_load(load), .i_load_addr(load_addr), .i_load_data(load_data)
`endif
  );

  gpr_serial_bank #(.WIDTH(8), .NREGS(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_start(start5), .i_addr(addr5), .i_mode(mode5),
    .i_data_in(data_in5), .o_data_out(data_out5), .o_busy(busy5), .o_done(done5),
    .o_err(err5), .o_regs(regs5)
`ifdef GPR_PARLOAD_EN
    , .i_load(load5), .i_load_addr(load_addr5), .i_load_data(load_data5)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] model [4];
  logic exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  // One serial transfer on the 4x8 bank. Expected read bits are queued at issue time and
  // popped on each busy cycle. inj_cyc >= 0 presents a write start to reg1 during that busy cycle.
  task automatic run_xfer(input logic [1:0] a, input logic [1:0] m, input logic [7:0] wdata,
                          input int inj_cyc);
    int   busy_cnt = 0;
    bit   seen = 0;
    logic exp_bit;
    for (int i = 0; i < W; i++) exp_q.push_back(model[a][i]);
    case (m)
      2'b01:   model[a] = wdata;
      2'b00:   model[a] = '0;
      default: ;
    endcase
    start = 1'b1; addr = a; mode = m;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL data_out: got busy cycle %0d required no further busy cycle", busy_cnt);
          end else begin
            exp_bit = exp_q.pop_front();
            if (data_out !== exp_bit) begin
              errors++;
              $display("FAIL data_out bit %0d: got %b required %b", busy_cnt, data_out, exp_bit);
            end
          end
          if (busy_cnt < W) data_in = wdata[busy_cnt];
          if (busy_cnt == inj_cyc) begin
            start = 1'b1; addr = 2'd1; mode = 2'b01;
          end else begin
            start = 1'b0;
          end
          busy_cnt++;
        end
        tick();
      end
    end
    start = 1'b0;
    exp_q.delete();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done pulse required one within 20 cycles");
    end
    checks++;
    if (busy_cnt != W) begin
      errors++;
      $display("FAIL busy_len: got %0d required %0d", busy_cnt, W);
    end
    checks++;
    if (regs !== model_flat()) begin
      errors++;
      $display("FAIL regs_after_xfer: got %h required %h", regs, model_flat());
    end
    $display("xfer addr=%0d mode=%0d busy_cycles=%0d regs=%h", a, m, busy_cnt, regs);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    checks++;
    if (regs !== 32'h0 || regs5 !== 40'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h/%h required 0", regs, regs5);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b dout=%b err=%b required 0",
               busy, done, data_out, err);
    end
    $display("reset regs=%h", regs);
  endtask

  task automatic test_write();
    run_xfer(2'd2, 2'b01, 8'h4D, -1);
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: got %b required 0", done);
    end
    checks++;
    if (regs !== 32'h004D_0000) begin
      errors++;
      $display("FAIL write_value: got %h required %h", regs, 32'h004D_0000);
    end
  endtask

  task automatic test_rotate();
    run_xfer(2'd2, 2'b10, 8'hFF, -1);
    checks++;
    if (regs[23:16] !== 8'h4D) begin
      errors++;
      $display("FAIL rotate_keep: got %h required 4d", regs[23:16]);
    end
  endtask

  task automatic test_clear();
    run_xfer(2'd2, 2'b00, 8'hFF, 3);
    checks++;
    if (regs[15:8] !== 8'h00 || regs[23:16] !== 8'h00) begin
      errors++;
      $display("FAIL clear_and_ignore: got reg1=%h reg2=%h required 00 00", regs[15:8], regs[23:16]);
    end
  endtask

  task automatic test_back_to_back();
    run_xfer(2'd1, 2'b01, 8'h96, -1);
    run_xfer(2'd1, 2'b11, 8'h00, -1);
    checks++;
    if (regs[15:8] !== 8'h96) begin
      errors++;
      $display("FAIL back_to_back: got %h required 96", regs[15:8]);
    end
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    int busy_cnt = 0;
    run_xfer(2'd3, 2'b01, 8'h3C, -1);
    start = 1'b1; addr = 2'd0; mode = 2'b01; data_in = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (regs !== 32'h0) begin
      errors++;
      $display("FAIL abort_regs: got %h required 0", regs);
    end
    for (int i = 0; i < 10; i++) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      tick();
    end
    checks++;
    if (done_cnt != 0 || busy_cnt != 0) begin
      errors++;
      $display("FAIL abort_quiet: got done=%0d busy=%0d cycles required 0 0", done_cnt, busy_cnt);
    end
    $display("abort regs=%h", regs);
  endtask

  task automatic test_err();
    start5 = 1'b1; addr5 = 3'd5; mode5 = 2'b01; data_in5 = 1'b1;
    tick();
    start5 = 1'b0;
    checks++;
    if (err5 !== 1'b1 || busy5 !== 1'b0 || regs5 !== 40'h0) begin
      errors++;
      $display("FAIL err_pulse: got err=%b busy=%b regs=%h required 1 0 0", err5, busy5, regs5);
    end
    tick();
    checks++;
    if (err5 !== 1'b0 || busy5 !== 1'b0 || done5 !== 1'b0) begin
      errors++;
      $display("FAIL err_single: got err=%b busy=%b done=%b required 0 0 0", err5, busy5, done5);
    end
    start5 = 1'b1; addr5 = 3'd4;
    tick();
    start5 = 1'b0;
    checks++;
    if (err5 !== 1'b0 || busy5 !== 1'b1) begin
      errors++;
      $display("FAIL top_addr_accept: got err=%b busy=%b required 0 1", err5, busy5);
    end
    for (int i = 0; i < W; i++) tick();
    checks++;
    if (done5 !== 1'b1 || regs5 !== 40'hFF_0000_0000) begin
      errors++;
      $display("FAIL top_addr_write: got done=%b regs=%h required 1 ff00000000", done5, regs5);
    end
    $display("err/top-addr regs5=%h", regs5);
  endtask

`ifdef GPR_PARLOAD_EN
  task automatic test_parload();
    int cyc = 0;
    load = 1'b1; load_addr = 2'd1; load_data = 8'hA5;
    tick();
    load = 1'b0;
    model[1] = 8'hA5;
    checks++;
    if (regs[15:8] !== 8'hA5 || regs !== model_flat()) begin
      errors++;
      $display("FAIL parload_idle: got %h required %h", regs, model_flat());
    end
    start = 1'b1; addr = 2'd1; mode = 2'b10;
    tick();
    start = 1'b0;
    load = 1'b1; load_addr = 2'd0; load_data = 8'hFF;
    tick();
    load = 1'b0;
    while (busy && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (busy !== 1'b0 || regs !== model_flat()) begin
      errors++;
      $display("FAIL parload_in_shift: got busy=%b regs=%h required 0 %h", busy, regs, model_flat());
    end
    tick();
    load = 1'b1; load_addr = 2'd2; load_data = 8'h5A;
    start = 1'b1; addr = 2'd1; mode = 2'b00;
    tick();
    load = 1'b0; start = 1'b0;
    model[2] = 8'h5A;
    checks++;
    if (busy !== 1'b0 || regs !== model_flat()) begin
      errors++;
      $display("FAIL parload_vs_start: got busy=%b regs=%h required 0 %h", busy, regs, model_flat());
    end
    $display("parload regs=%h", regs);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_rotate();
    test_clear();
    test_back_to_back();
    test_abort();
    test_err();
`ifdef GPR_PARLOAD_EN
    test_parload();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
